// File: rtl/hydrophone_toa_capture_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hydrophone_toa_capture_if                                                  |
// | Arm / ping-detect inputs and distances handshake of the TOA capture block. |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface hydrophone_toa_capture_if #(
  parameter int N     = 3,
  parameter int CNT_W = 8
);
  logic               arm;
  logic [N-1:0]       ping_det;
  logic               dist_ready;
  logic               dist_valid;
  logic [N*CNT_W-1:0] distances;
  logic [N-1:0]       captured_mask;
  logic               timeout_err;
  logic               busy;

  modport master (
    output arm, ping_det, dist_ready,
    input  dist_valid, distances, captured_mask, timeout_err, busy
  );

  modport slave (
    input  arm, ping_det, dist_ready,
    output dist_valid, distances, captured_mask, timeout_err, busy
  );
endinterface
`default_nettype wire

// File: rtl/hydrophone_toa_capture.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | hydrophone_toa_capture                                                     |
// | Timestamps each channel's first fresh rising edge relative to the earliest |
// | and presents the delays to the triangulation stage via valid/ready.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module hydrophone_toa_capture #(
  parameter int N       = 3,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 200,
  parameter int HOLDOFF = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  hydrophone_toa_capture_if.slave  bus
);

  // The counter serves both the arrival window and the echo holdoff.
  localparam int C_HW = $clog2(HOLDOFF + 1);
  localparam int C_CW = (CNT_W > C_HW) ? CNT_W : C_HW;

  localparam logic [C_CW-1:0]  C_TIMEOUT   = C_CW'(TIMEOUT);
  localparam logic [C_CW-1:0]  C_HOLD_LAST = C_CW'(HOLDOFF - 1);
  localparam logic [C_CW-1:0]  C_ONE       = 1;
  localparam logic [CNT_W-1:0] C_MISSING   = '1;
  localparam logic [N-1:0]     C_ALL       = '1;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_WAIT_FIRST = 3'd1,
    S_CAPTURE    = 3'd2,
    S_PRESENT    = 3'd3,
    S_HOLD       = 3'd4
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [C_CW-1:0]    r_cnt, w_cnt_nxt;
  logic [N-1:0]       r_prev;
  logic [N-1:0]       r_mask, w_mask_nxt;
  logic [N*CNT_W-1:0] r_dist, w_dist_nxt;
  logic               r_err, w_err_nxt;
  logic               r_valid, w_valid_nxt;
  logic               r_busy;
  logic [N-1:0]       w_edge;
  logic [N-1:0]       w_new;

  assign w_edge = bus.ping_det & ~r_prev;
  assign w_new  = w_edge & ~r_mask;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_mask_nxt  = r_mask;
    w_dist_nxt  = r_dist;
    w_err_nxt   = r_err;
    w_valid_nxt = r_valid;
    case (r_state)
      S_IDLE: begin
        if (bus.arm) begin
          w_state_nxt = S_WAIT_FIRST;
          w_cnt_nxt   = '0;
          w_mask_nxt  = '0;
          w_dist_nxt  = '0;
          w_err_nxt   = 1'b0;
        end
      end
      S_WAIT_FIRST: begin
        if (|w_edge) begin
          for (int i = 0; i < N; i++) begin
            if (w_edge[i]) begin
              w_dist_nxt[i*CNT_W +: CNT_W] = '0;
            end
          end
          w_mask_nxt = w_edge;
          w_cnt_nxt  = C_ONE;
          if (w_edge == C_ALL) begin
            w_state_nxt = S_PRESENT;
            w_valid_nxt = 1'b1;
          end else begin
            w_state_nxt = S_CAPTURE;
          end
        end
      end
      S_CAPTURE: begin
        // Edges landing exactly on the timeout cycle are deliberately dropped.
        if (r_cnt == C_TIMEOUT) begin
          for (int i = 0; i < N; i++) begin
            if (!r_mask[i]) begin
              w_dist_nxt[i*CNT_W +: CNT_W] = C_MISSING;
            end
          end
          w_err_nxt   = 1'b1;
          w_state_nxt = S_PRESENT;
          w_valid_nxt = 1'b1;
        end else begin
          for (int i = 0; i < N; i++) begin
            if (w_new[i]) begin
              w_dist_nxt[i*CNT_W +: CNT_W] = r_cnt[CNT_W-1:0];
            end
          end
          w_mask_nxt = r_mask | w_new;
          if ((r_mask | w_new) == C_ALL) begin
            w_state_nxt = S_PRESENT;
            w_valid_nxt = 1'b1;
          end else begin
            w_cnt_nxt = r_cnt + C_ONE;
          end
        end
      end
      S_PRESENT: begin
        if (bus.dist_ready) begin
          w_valid_nxt = 1'b0;
          w_cnt_nxt   = '0;
          w_state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        if (r_cnt == C_HOLD_LAST) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt_nxt = r_cnt + C_ONE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_prev  <= '0;
      r_mask  <= '0;
      r_dist  <= '0;
      r_err   <= 1'b0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_prev  <= bus.ping_det;
      r_mask  <= w_mask_nxt;
      r_dist  <= w_dist_nxt;
      r_err   <= w_err_nxt;
      r_valid <= w_valid_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  assign bus.dist_valid    = r_valid;
  assign bus.distances     = r_dist;
  assign bus.captured_mask = r_mask;
  assign bus.timeout_err   = r_err;
  assign bus.busy          = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_hydrophone_toa_capture.sv
`timescale 1ns/1ps
`default_nettype none
// Bench for hydrophone_toa_capture: a timestamp-based arrival model checked every
// cycle, plus hand-computed literal expectations for the directed scenarios.
module tb_hydrophone_toa_capture;
  localparam int N       = 3;
  localparam int CNT_W   = 8;
  localparam int TIMEOUT = 20;
  localparam int HOLDOFF = 4;
  localparam int W       = 48;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  hydrophone_toa_capture_if #(.N(N), .CNT_W(CNT_W)) bus ();

  hydrophone_toa_capture #(
    .N(N), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .HOLDOFF(HOLDOFF)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Model: absolute cycle stamps of arm, first arrival, result, handshake.
  bit           m_active;
  int           m_cyc, m_t0, m_done, m_hs;
  int           m_arr[N];
  logic [N-1:0] m_prev, m_rise;

  function automatic bit all_arrived();
    for (int i = 0; i < N; i++) if (m_arr[i] < 0) return 1'b0;
    return 1'b1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0;
      m_cyc = 0; m_t0 = -1; m_done = -1; m_hs = -1;
      m_prev = '0;
      for (int i = 0; i < N; i++) m_arr[i] = -1;
    end else begin
      m_cyc++;
      m_rise = bus.ping_det & ~m_prev;
      if (!m_active) begin
        if (bus.arm) begin
          m_active = 1'b1;
          m_t0 = -1; m_done = -1; m_hs = -1;
          for (int i = 0; i < N; i++) m_arr[i] = -1;
        end
      end else if (m_t0 < 0) begin
        if (m_rise != '0) begin
          m_t0 = m_cyc;
          for (int i = 0; i < N; i++) if (m_rise[i]) m_arr[i] = 0;
          if (all_arrived()) m_done = m_cyc;
        end
      end else if (m_done < 0) begin
        if (m_cyc - m_t0 >= TIMEOUT) m_done = m_cyc;
        else begin
          for (int i = 0; i < N; i++)
            if (m_rise[i] && m_arr[i] < 0) m_arr[i] = m_cyc - m_t0;
          if (all_arrived()) m_done = m_cyc;
        end
      end else if (m_hs < 0) begin
        if (bus.dist_ready) m_hs = m_cyc;
      end else if (m_cyc - m_hs >= HOLDOFF) begin
        m_active = 1'b0;
      end
      m_prev = bus.ping_det;
    end
  end

  function automatic logic [N*CNT_W-1:0] exp_dist();
    logic [N*CNT_W-1:0] d = '0;
    for (int i = 0; i < N; i++)
      d[i*CNT_W +: CNT_W] = (m_arr[i] < 0) ? {CNT_W{1'b1}} : m_arr[i][CNT_W-1:0];
    return d;
  endfunction

  function automatic logic [N-1:0] exp_mask();
    logic [N-1:0] m = '0;
    for (int i = 0; i < N; i++) m[i] = (m_arr[i] >= 0);
    return m;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_valid", 64'(bus.dist_valid), 64'd0);
      check("rst_busy",  64'(bus.busy), 64'd0);
      check("rst_dist",  64'(bus.distances), 64'd0);
      check("rst_mask",  64'(bus.captured_mask), 64'd0);
      check("rst_err",   64'(bus.timeout_err), 64'd0);
    end else begin
      check("busy",  64'(bus.busy), 64'(m_active));
      check("valid", 64'(bus.dist_valid), 64'(m_active && m_done >= 0 && m_hs < 0));
      if (m_active && m_done >= 0 && m_hs < 0) begin
        check("dist", 64'(bus.distances), 64'(exp_dist()));
        check("mask", 64'(bus.captured_mask), 64'(exp_mask()));
        check("err",  64'(bus.timeout_err), 64'(exp_mask() != '1));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_arm();
    bus.arm = 1'b1;
    tick(1);
    bus.arm = 1'b0;
  endtask

  // Bit j of a pattern is the level sampled j edges after play starts; t0 sits at j=2.
  function automatic logic [W-1:0] pulse(input int at);
    logic [W-1:0] p = '0;
    p[at+2] = 1'b1;
    p[at+3] = 1'b1;
    return p;
  endfunction

  task automatic play(input logic [W-1:0] p0, input logic [W-1:0] p1, input logic [W-1:0] p2);
    for (int j = 0; j < W; j++) begin
      bus.ping_det = {p2[j], p1[j], p0[j]};
      tick(1);
    end
    bus.ping_det = '0;
  endtask

  task automatic expect_result(input string tag, input logic [N*CNT_W-1:0] d,
                               input logic [N-1:0] m, input logic e);
    for (int k = 0; k < 60 && !bus.dist_valid; k++) tick(1);
    check({tag, "_valid"}, 64'(bus.dist_valid), 64'd1);
    check({tag, "_dist"},  64'(bus.distances), 64'(d));
    check({tag, "_mask"},  64'(bus.captured_mask), 64'(m));
    check({tag, "_err"},   64'(bus.timeout_err), 64'(e));
  endtask

  task automatic finish_cap(input string tag);
    bus.dist_ready = 1'b1;
    tick(1);
    bus.dist_ready = 1'b0;
    check({tag, "_drop"}, 64'(bus.dist_valid), 64'd0);
    tick(HOLDOFF - 1);
    check({tag, "_hold"}, 64'(bus.busy), 64'd1);
    tick(1);
    check({tag, "_idle"}, 64'(bus.busy), 64'd0);
    tick(2);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.arm = 1'b0;
    bus.ping_det = '0;
    bus.dist_ready = 1'b0;
    tick(2);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_dist", 64'(bus.distances), 64'd0);
    rst_n = 1'b1;
    tick(2);

    // 1: staggered arrivals ch1, ch0 +3, ch2 +7
    do_arm();
    play(pulse(3), pulse(0), pulse(7));
    expect_result("c1", 24'h07_00_03, 3'b111, 1'b0);
    finish_cap("c1");

    // 2: simultaneous arrivals
    do_arm();
    tick(1);
    bus.ping_det = 3'b111;
    tick(1);
    check("c2_valid", 64'(bus.dist_valid), 64'd1);
    check("c2_dist",  64'(bus.distances), 64'd0);
    check("c2_mask",  64'(bus.captured_mask), 64'(3'b111));
    bus.ping_det = '0;
    finish_cap("c2");

    // 3: ch2 lands exactly on the timeout cycle
    do_arm();
    play(pulse(0), pulse(5), pulse(20));
    expect_result("c3", 24'hFF_05_00, 3'b011, 1'b1);
    finish_cap("c3");

    // 4: stall with extra pulses, then pulses during holdoff
    do_arm();
    play(pulse(3), pulse(0), pulse(7));
    expect_result("c4a", 24'h07_00_03, 3'b111, 1'b0);
    play(pulse(0), pulse(1), pulse(2));
    expect_result("c4b", 24'h07_00_03, 3'b111, 1'b0);
    bus.dist_ready = 1'b1;
    tick(1);
    bus.dist_ready = 1'b0;
    check("c4_drop", 64'(bus.dist_valid), 64'd0);
    bus.ping_det = 3'b111;
    tick(1);
    bus.ping_det = '0;
    tick(2);
    check("c4_hold", 64'(bus.busy), 64'd1);
    tick(1);
    check("c4_idle", 64'(bus.busy), 64'd0);
    tick(10);
    check("c4_quiet_valid", 64'(bus.dist_valid), 64'd0);
    check("c4_quiet_busy",  64'(bus.busy), 64'd0);

    // 5: level high before arm, ch0 re-pulses
    bus.ping_det = 3'b001;
    tick(3);
    do_arm();
    play(pulse(0) | pulse(4), pulse(2), pulse(6));
    expect_result("c5", 24'h06_02_00, 3'b111, 1'b0);
    finish_cap("c5");

    // 6: asynchronous reset mid-capture, then case 1 again
    do_arm();
    bus.ping_det = 3'b010;
    tick(3);
    check("c6_pre_busy", 64'(bus.busy), 64'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("c6_async_busy", 64'(bus.busy), 64'd0);
    check("c6_async_mask", 64'(bus.captured_mask), 64'd0);
    check("c6_async_valid", 64'(bus.dist_valid), 64'd0);
    bus.ping_det = '0;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    do_arm();
    play(pulse(3), pulse(0), pulse(7));
    expect_result("c6", 24'h07_00_03, 3'b111, 1'b0);
    finish_cap("c6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
